packet_tx_serializer: RTL and testbench

PACKET_TX_SERIALIZER -- requirements
Module: packet_tx_serializer

---
 rtl/pkt_pkg.sv | 31 +++
 rtl/pkt_tx_checksum.sv | 26 ++
 rtl/packet_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_packet_tx_serializer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet transmit serializer.
// Beat count depends on PKT_TX_CHECKSUM_EN (adds one trailing checksum beat).
package pkt_pkg;

    localparam int BEAT_W     = 32;
    // {src, dest, seq[7:0]} must fit in one beat, so addresses are at most 12 bits
    localparam int ADDR_W_MAX = 12;

    typedef struct packed {
        logic [31:0]           id;
        logic [ADDR_W_MAX-1:0] src;
        logic [ADDR_W_MAX-1:0] dest;
    } pkt_hdr_t;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        LOAD,
        SEND
    } tx_state_e;

    function automatic int beat_count(input int payload_w);
        int n;
        n = 2 + payload_w / BEAT_W;
`ifdef PKT_TX_CHECKSUM_EN
        n = n + 1;
`endif
        return n;
    endfunction

endpackage

// File: rtl/pkt_tx_checksum.sv
// Running XOR accumulator over accepted beats; clr has priority over en.
// Only instantiated when PKT_TX_CHECKSUM_EN is defined.
module pkt_tx_checksum
    import pkt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [BEAT_W-1:0] data,
    output logic [BEAT_W-1:0] sum
);

    logic [BEAT_W-1:0] sum_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum_reg <= '0;
        end else if (en) begin
            sum_reg <= sum_reg ^ data;
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/packet_tx_serializer.sv
// Pops packets from an upstream queue and serializes them as 32-bit beats:
// id, {src,dest,seq}, payload words MSW first, plus a checksum beat under PKT_TX_CHECKSUM_EN.
module packet_tx_serializer
    import pkt_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int PAYLOAD_W = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 q_empty,
    output logic                 q_pop,
    input  logic [31:0]          in_id,
    input  logic [ADDR_W-1:0]    in_src,
    input  logic [ADDR_W-1:0]    in_dest,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [31:0]          tx_data,
    output logic                 tx_last,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);

    localparam int NWORDS = PAYLOAD_W / BEAT_W;
    localparam int BEATS  = beat_count(PAYLOAD_W);
    localparam int IDX_W  = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    tx_state_e            state_reg;
    tx_state_e            state_next;
    logic [IDX_W-1:0]     beat_idx_reg;
    pkt_hdr_t             hdr_reg;
    logic [PAYLOAD_W-1:0] payload_reg;
    logic [7:0]           seq_reg;
    logic [7:0]           seq_frame_reg;
    logic [15:0]          frame_cnt_reg;

    logic                 fire;
    logic                 last_fire;
    logic [BEAT_W-1:0]    addr_beat;
    logic [BEAT_W-1:0]    beat_data;
    logic [BEAT_W-1:0]    payload_words [NWORDS];

    assign fire      = (state_reg == SEND) && tx_ready;
    assign last_fire = fire && (beat_idx_reg == LAST_IDX);

    // Stored addresses are zero-extended, so the shifts leave the MSBs clear
    assign addr_beat = (BEAT_W'(hdr_reg.src) << (ADDR_W + 8))
                     | (BEAT_W'(hdr_reg.dest) << 8)
                     | BEAT_W'(seq_frame_reg);

    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
        assign payload_words[gi] = payload_reg[PAYLOAD_W-1-gi*BEAT_W -: BEAT_W];
    end

`ifdef PKT_TX_CHECKSUM_EN
    logic [BEAT_W-1:0] csum;

    pkt_tx_checksum u_checksum (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_reg == LOAD),
        .en   (fire),
        .data (beat_data),
        .sum  (csum)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!q_empty) state_next = POP;
            POP:     state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    if (last_fire) state_next = q_empty ? IDLE : POP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        q_pop    = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = '0;
        busy     = (state_reg != IDLE);
        case (state_reg)
            POP: q_pop = 1'b1;
            SEND: begin
                tx_valid = 1'b1;
                tx_last  = (beat_idx_reg == LAST_IDX);
                tx_data  = beat_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        beat_data = '0;
        if (beat_idx_reg == IDX_W'(0)) begin
            beat_data = hdr_reg.id;
        end else if (beat_idx_reg == IDX_W'(1)) begin
            beat_data = addr_beat;
        end
        for (int i = 0; i < NWORDS; i++) begin
            if (beat_idx_reg == IDX_W'(i + 2)) begin
                beat_data = payload_words[i];
            end
        end
`ifdef PKT_TX_CHECKSUM_EN
        if (beat_idx_reg == LAST_IDX) begin
            beat_data = csum;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx_reg  <= '0;
            hdr_reg       <= '0;
            payload_reg   <= '0;
            seq_reg       <= '0;
            seq_frame_reg <= '0;
            frame_cnt_reg <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    hdr_reg.id    <= in_id;
                    hdr_reg.src   <= ADDR_W_MAX'(in_src);
                    hdr_reg.dest  <= ADDR_W_MAX'(in_dest);
                    payload_reg   <= in_payload;
                    seq_frame_reg <= seq_reg;
                    beat_idx_reg  <= '0;
                end
                SEND: begin
                    if (last_fire) begin
                        beat_idx_reg  <= '0;
                        seq_reg       <= seq_reg + 8'd1;
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    end else if (fire) begin
                        beat_idx_reg <= beat_idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_packet_tx_serializer.sv
// Scoreboard bench for packet_tx_serializer: a queue model feeds packets,
// expected beats are queued at enqueue time and compared as the link accepts them.
module tb_packet_tx_serializer;

    localparam int ADDR_W    = 8;
    localparam int PAYLOAD_W = 128;
`ifdef PKT_TX_CHECKSUM_EN
    localparam int BEATS = 7;
`else
    localparam int BEATS = 6;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 q_empty = 1'b1;
    logic                 q_pop;
    logic [31:0]          in_id = '0;
    logic [ADDR_W-1:0]    in_src = '0;
    logic [ADDR_W-1:0]    in_dest = '0;
    logic [PAYLOAD_W-1:0] in_payload = '0;
    logic                 tx_valid;
    logic                 tx_ready = 1'b1;
    logic [31:0]          tx_data;
    logic                 tx_last;
    logic                 busy;
    logic [15:0]          frame_cnt;

    typedef struct {
        logic [31:0]  id;
        logic [7:0]   src;
        logic [7:0]   dest;
        logic [127:0] payload;
    } pkt_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } cap_t;

    pkt_t  src_q[$];
    beat_t exp_q[$];
    cap_t  cap_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    logic [7:0] model_seq = 8'd0;

    packet_tx_serializer #(
        .ADDR_W    (ADDR_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_empty    (q_empty),
        .q_pop      (q_pop),
        .in_id      (in_id),
        .in_src     (in_src),
        .in_dest    (in_dest),
        .in_payload (in_payload),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Upstream queue model: data presented right after the pop cycle
    initial begin
        pkt_t p;
        forever begin
            @(negedge clk);
            if (!rst && q_pop && src_q.size() > 0) begin
                p = src_q.pop_front();
                in_id      = p.id;
                in_src     = p.src;
                in_dest    = p.dest;
                in_payload = p.payload;
            end
            q_empty = (src_q.size() == 0);
        end
    end

    // Link monitor: every accepted beat is captured and scored
    initial begin
        cap_t  c;
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && tx_valid && tx_ready) begin
                c.data = tx_data;
                c.last = tx_last;
                c.cyc  = cyc;
                cap_q.push_back(c);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got=%h exp=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e.data || tx_last !== e.last) begin
                        errors++;
                        $display("FAIL beat got=%h/%b exp=%h/%b", tx_data, tx_last, e.data, e.last);
                    end else begin
                        $display("beat data=%h last=%b cyc=%0d", tx_data, tx_last, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic pkt_t lit_pkt();
        pkt_t p;
        p.id      = 32'h11223344;
        p.src     = 8'h0A;
        p.dest    = 8'h0B;
        p.payload = {32'h1, 32'h2, 32'h3, 32'h4};
        return p;
    endfunction

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.id      = $urandom;
        p.src     = 8'($urandom);
        p.dest    = 8'($urandom);
        p.payload = {$urandom, $urandom, $urandom, $urandom};
        return p;
    endfunction

    task automatic enqueue(input pkt_t p);
        beat_t       b;
        logic [31:0] w;
        logic [31:0] x;
        x = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (k == 0)      w = p.id;
            else if (k == 1) w = {8'h00, p.src, p.dest, model_seq};
            else if (k < 6)  w = p.payload[127 - 32*(k-2) -: 32];
            else             w = x;
            x = x ^ w;
            b.data = w;
            b.last = (k == BEATS - 1);
            exp_q.push_back(b);
        end
        model_seq = model_seq + 8'd1;
        src_q.push_back(p);
    endtask

    task automatic flush_model();
        src_q.delete();
        exp_q.delete();
        cap_q.delete();
        model_seq = 8'd0;
        tx_ready  = 1'b1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        flush_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        @(posedge clk); #1;
        rst = 1'b1;
        flush_model();
        repeat (2) @(posedge clk);
        #1 enqueue(rand_pkt());
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (q_pop !== 1'b0)     begin errors++; $display("FAIL rst_q_pop got=%b exp=0", q_pop); end
        if (tx_valid !== 1'b0)  begin errors++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        if (tx_last !== 1'b0)   begin errors++; $display("FAIL rst_tx_last got=%b exp=0", tx_last); end
        if (tx_data !== 32'h0)  begin errors++; $display("FAIL rst_tx_data got=%h exp=0", tx_data); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (q_pop !== 1'b0) begin errors++; $display("FAIL first_cycle_pop got=%b exp=0", q_pop); end
        @(negedge clk);
        checks++;
        if (q_pop !== 1'b1) begin errors++; $display("FAIL second_cycle_pop got=%b exp=1", q_pop); end
        wait_done(100, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL reset_timeout got=busy exp=idle"); end
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL reset_frame_cnt got=%0d exp=1", frame_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        bit          ok;
        logic [31:0] ref_beats [6];
        ref_beats = '{32'h11223344, 32'h000A0B00, 32'h1, 32'h2, 32'h3, 32'h4};
        apply_reset();
        enqueue(lit_pkt());
        wait_done(100, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL single_timeout got=busy exp=idle"); end
        if (cap_q.size() != BEATS) begin errors++; $display("FAIL single_beats got=%0d exp=%0d", cap_q.size(), BEATS); end
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt got=%0d exp=1", frame_cnt); end
        for (int k = 0; k < 6 && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k].data !== ref_beats[k] || cap_q[k].last !== (k == BEATS - 1)) begin
                errors++;
                $display("FAIL single_beat%0d got=%h/%b exp=%h/%b", k, cap_q[k].data, cap_q[k].last, ref_beats[k], (k == BEATS - 1));
            end
        end
`ifdef PKT_TX_CHECKSUM_EN
        // 0x11223344 ^ 0x000A0B00 = 0x11283844; ^1^2^3^4 (=4) gives 0x11283840
        if (cap_q.size() > 6) begin
            checks++;
            if (cap_q[6].data !== 32'h11283840 || cap_q[6].last !== 1'b1) begin
                errors++;
                $display("FAIL single_checksum got=%h/%b exp=11283840/1", cap_q[6].data, cap_q[6].last);
            end
        end
`endif
        $display("test_single done");
    endtask

    task automatic test_backpressure();
        bit ok;
        apply_reset();
        enqueue(lit_pkt());
        for (int t = 0; t < 50 && cap_q.size() < 2; t++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (cap_q.size() != 2) begin errors++; $display("FAIL bp_reach_beat2 got=%0d exp=2", cap_q.size()); end
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 32'h1 || tx_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/00000001/0", i, tx_valid, tx_data, tx_last);
            end
            @(posedge clk);
        end
        #1 tx_ready = 1'b1;
        wait_done(100, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL bp_timeout got=busy exp=idle"); end
        if (cap_q.size() != BEATS) begin errors++; $display("FAIL bp_beats got=%0d exp=%0d", cap_q.size(), BEATS); end
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL bp_frame_cnt got=%0d exp=1", frame_cnt); end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gap;
        apply_reset();
        for (int i = 0; i < 3; i++) enqueue(rand_pkt());
        wait_done(200, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL b2b_timeout got=busy exp=idle"); end
        if (cap_q.size() != 3 * BEATS) begin errors++; $display("FAIL b2b_beats got=%0d exp=%0d", cap_q.size(), 3 * BEATS); end
        if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_frame_cnt got=%0d exp=3", frame_cnt); end
        if (cap_q.size() == 3 * BEATS) begin
            for (int f = 0; f < 3; f++) begin
                checks++;
                if (cap_q[f*BEATS+1].data[7:0] !== 8'(f)) begin
                    errors++;
                    $display("FAIL b2b_seq%0d got=%0d exp=%0d", f, cap_q[f*BEATS+1].data[7:0], f);
                end
            end
            for (int f = 0; f < 2; f++) begin
                gap = cap_q[(f+1)*BEATS].cyc - cap_q[f*BEATS+BEATS-1].cyc - 1;
                checks++;
                if (gap != 2) begin errors++; $display("FAIL b2b_gap%0d got=%0d exp=2", f, gap); end
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_seq_wrap();
        bit ok;
        apply_reset();
        for (int i = 0; i < 257; i++) enqueue(rand_pkt());
        wait_done(257 * 12 + 100, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL wrap_timeout got=busy exp=idle"); end
        if (cap_q.size() != 257 * BEATS) begin errors++; $display("FAIL wrap_beats got=%0d exp=%0d", cap_q.size(), 257 * BEATS); end
        if (frame_cnt !== 16'd257) begin errors++; $display("FAIL wrap_frame_cnt got=%0d exp=257", frame_cnt); end
        if (cap_q.size() == 257 * BEATS) begin
            checks += 2;
            if (cap_q[255*BEATS+1].data[7:0] !== 8'hFF) begin
                errors++; $display("FAIL wrap_seq255 got=%h exp=ff", cap_q[255*BEATS+1].data[7:0]);
            end
            if (cap_q[256*BEATS+1].data[7:0] !== 8'h00) begin
                errors++; $display("FAIL wrap_seq256 got=%h exp=00", cap_q[256*BEATS+1].data[7:0]);
            end
        end
        $display("test_seq_wrap done");
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        enqueue(rand_pkt());
        for (int t = 0; t < 50 && cap_q.size() < 4; t++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (cap_q.size() != 4) begin errors++; $display("FAIL mid_reach_beat3 got=%0d exp=4", cap_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        flush_model();
        @(negedge clk);
        checks += 3;
        if (tx_valid !== 1'b0)   begin errors++; $display("FAIL mid_tx_valid got=%b exp=0", tx_valid); end
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt got=%0d exp=0", frame_cnt); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        @(posedge clk); #1 rst = 1'b0;
        enqueue(lit_pkt());
        wait_done(100, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL mid_timeout got=busy exp=idle"); end
        if (cap_q.size() < 2 || cap_q[1].data !== 32'h000A0B00) begin
            errors++; $display("FAIL mid_next_seq got=%h exp=000a0b00", (cap_q.size() < 2) ? 32'hx : cap_q[1].data);
        end
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_next_frame_cnt got=%0d exp=1", frame_cnt); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_seq_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
